// File: rtl/saida_bcd_display.sv
// Output stage: captures IO write-back values and converts them sequentially (shift-add-3) to eight 7-segment digits.
// Optional build macro SAIDA_SIGNED_EN: two's-complement input with a sign dash on display7.
module saida_bcd_display #(
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int CONV_BITS      = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        IO,
   input  logic [31:0] saida,
   output logic        busy,
   output logic        overflow,
   output logic [6:0]  display0,
   output logic [6:0]  display1,
   output logic [6:0]  display2,
   output logic [6:0]  display3,
   output logic [6:0]  display4,
   output logic [6:0]  display5,
   output logic [6:0]  display6,
   output logic [6:0]  display7
);

   typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, UPDATE = 2'd2} state_t;

   localparam int CW = $clog2(CONV_BITS) + 1;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
`ifdef SAIDA_SIGNED_EN
   localparam int TOP = 6;
`else
   localparam int TOP = 7;
`endif

   state_t        state_r;
   state_t        state_s;
   logic [31:0]   shreg_r;
   logic [39:0]   bcd_r;
   logic [39:0]   bcd_adj_s;
   logic [CW-1:0] cnt_r;
   logic [31:0]   pend_r;
   logic          pend_valid_r;
   logic          busy_r;
   logic          overflow_r;
   logic          ovf_s;
   logic          start_s;
   logic [31:0]   load_val_s;
   logic [6:0]    disp_r [8];
   logic [6:0]    disp_s [8];
`ifdef SAIDA_SIGNED_EN
   logic          neg_r;
`endif

   // Active-low segment code for one BCD digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b0111111;
      endcase
   endfunction

   function automatic logic [6:0] pol(input logic [6:0] c);
      pol = (SEG_ACTIVE_LOW != 0) ? c : ~c;
   endfunction

   function automatic logic [31:0] magnitude(input logic [31:0] v);
`ifdef SAIDA_SIGNED_EN
      magnitude = v[31] ? (32'd0 - v) : v;
`else
      magnitude = v;
`endif
   endfunction

   // A conversion starts from IDLE on a strobe or leftover pending value, or back-to-back from UPDATE.
   assign start_s    = ((state_r == IDLE) && (IO || pend_valid_r)) ||
                       ((state_r == UPDATE) && pend_valid_r);
   assign load_val_s = ((state_r == IDLE) && IO) ? saida : pend_r;

   // Add-3 correction of every nibble before the shift.
   always_comb begin
      bcd_adj_s = bcd_r;
      for (int i = 0; i < 10; i++) begin
         if (bcd_r[i*4 +: 4] >= 4'd5) begin
            bcd_adj_s[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
         end else begin
            bcd_adj_s[i*4 +: 4] = bcd_r[i*4 +: 4];
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = start_s ? CONV : IDLE;
         CONV:    state_s = (cnt_r == CW'(CONV_BITS - 1)) ? UPDATE : CONV;
         UPDATE:  state_s = pend_valid_r ? CONV : IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Display decode with overflow dashes and leading-zero blanking.
   always_comb begin
      logic lead;
      lead = 1'b1;
`ifdef SAIDA_SIGNED_EN
      ovf_s = |bcd_r[39:28];
`else
      ovf_s = |bcd_r[39:32];
`endif
      for (int i = 0; i < 8; i++) begin
         disp_s[i] = SEG_BLANK;
      end
      for (int i = TOP; i >= 1; i--) begin
         if (lead && (bcd_r[i*4 +: 4] == 4'd0)) begin
            disp_s[i] = SEG_BLANK;
         end else begin
            disp_s[i] = seg7(bcd_r[i*4 +: 4]);
            lead      = 1'b0;
         end
      end
      disp_s[0] = seg7(bcd_r[3:0]);
`ifdef SAIDA_SIGNED_EN
      disp_s[7] = neg_r ? SEG_DASH : SEG_BLANK;
`endif
      if (ovf_s) begin
         for (int i = 0; i < 8; i++) begin
            disp_s[i] = SEG_DASH;
         end
      end else begin
         lead = 1'b0;
      end
   end

   // Conversion datapath, pending buffer and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         shreg_r      <= 32'd0;
         bcd_r        <= 40'd0;
         cnt_r        <= '0;
         pend_r       <= 32'd0;
         pend_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         overflow_r   <= 1'b0;
         disp_r[0]    <= pol(SEG_ZERO);
         for (int i = 1; i < 8; i++) begin
            disp_r[i] <= pol(SEG_BLANK);
         end
`ifdef SAIDA_SIGNED_EN
         neg_r        <= 1'b0;
`endif
      end else begin
         busy_r <= (state_s != IDLE);
         // A strobe while busy always lands in pending, even on the edge that consumes the old one.
         if (IO && (state_r != IDLE)) begin
            pend_r       <= saida;
            pend_valid_r <= 1'b1;
         end else if (start_s) begin
            pend_valid_r <= 1'b0;
         end
         if (state_r == UPDATE) begin
            overflow_r <= ovf_s;
            for (int i = 0; i < 8; i++) begin
               disp_r[i] <= pol(disp_s[i]);
            end
         end
         if (start_s) begin
            shreg_r <= magnitude(load_val_s);
            bcd_r   <= 40'd0;
            cnt_r   <= '0;
`ifdef SAIDA_SIGNED_EN
            neg_r   <= load_val_s[31];
`endif
         end else if (state_r == CONV) begin
            {bcd_r, shreg_r} <= {bcd_adj_s[38:0], shreg_r, 1'b0};
            cnt_r            <= cnt_r + CW'(1);
         end
      end
   end

   assign busy     = busy_r;
   assign overflow = overflow_r;
   assign display0 = disp_r[0];
   assign display1 = disp_r[1];
   assign display2 = disp_r[2];
   assign display3 = disp_r[3];
   assign display4 = disp_r[4];
   assign display5 = disp_r[5];
   assign display6 = disp_r[6];
   assign display7 = disp_r[7];

endmodule
